// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: load/start/pause/resume control over a multi-digit BCD down-counter.
// Optional CDT_ALARM_EN adds a blinking alarm output that toggles per tick while in DONE.

//  state   | meaning
//  IDLE    | counter loaded or reset, waiting for start
//  RUN     | counting down one BCD unit per tick
//  PAUSED  | countdown suspended, count held
//  DONE    | reached zero, count held at 0 until load or reset
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int TIME_MODE  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic                    start,
  input  logic                    pause,
  input  logic [4*NUM_DIGITS-1:0] prog_bcd,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    running,
  output logic                    done,
  output logic                    done_pulse
`ifdef CDT_ALARM_EN
  ,
  output logic                    alarm
`endif
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  state_t state;

  logic [W-1:0] count_dec;
  logic [W-1:0] prog_clamped;
  logic         borrow;
  logic         count_zero;
  logic         count_one;

  // Odd positions are tens-of-seconds / tens-of-minutes in time mode.
  function automatic logic [3:0] digit_max(input int pos);
    if (TIME_MODE == 1 && (pos % 2) == 1) digit_max = 4'd5;
    else                                  digit_max = 4'd9;
  endfunction

  always_comb begin
    prog_clamped = prog_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (prog_bcd[4*i +: 4] > digit_max(i)) prog_clamped[4*i +: 4] = digit_max(i);
    end
  end

  // Ripple borrow: zero digits wrap to their max until the first nonzero digit absorbs it.
  always_comb begin
    count_dec = count_bcd;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = digit_max(i);
        end else begin
          count_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_zero = (count_bcd == '0);
  assign count_one  = (count_bcd == {{(W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count_bcd  <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_PAUSED: begin
          if (load) begin
            state     <= ST_IDLE;
            count_bcd <= prog_clamped;
            running   <= 1'b0;
            done      <= 1'b0;
          end else if (pause) begin
            // pause outranks start but has no effect outside RUN
          end else if (start) begin
            if (count_zero) begin
              state      <= ST_DONE;
              running    <= 1'b0;
              done       <= 1'b1;
              done_pulse <= 1'b1;
            end else begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state   <= ST_PAUSED;
            running <= 1'b0;
          end else if (tick) begin
            count_bcd <= count_dec;
            if (count_one) begin
              state      <= ST_DONE;
              running    <= 1'b0;
              done       <= 1'b1;
              done_pulse <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (load) begin
            state     <= ST_IDLE;
            count_bcd <= prog_clamped;
            running   <= 1'b0;
            done      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          count_bcd <= '0;
          running   <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CDT_ALARM_EN
  // Any exit from DONE (load) or any state other than DONE forces the alarm low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alarm <= 1'b0;
    end else if (state == ST_DONE && !load) begin
      alarm <= alarm ^ tick;
    end else begin
      alarm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (NUM_DIGITS=4, TIME_MODE=1).
// Define CDT_ALARM_EN to also exercise the alarm output.
module tb_bcd_countdown_timer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        load;
  logic        start;
  logic        pause;
  logic [15:0] prog_bcd;
  logic [15:0] count_bcd;
  logic        running;
  logic        done;
  logic        done_pulse;
`ifdef CDT_ALARM_EN
  logic        alarm;
`endif

  int n_pass;
  int n_total;

  bcd_countdown_timer #(
    .NUM_DIGITS (4),
    .TIME_MODE  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .prog_bcd   (prog_bcd),
    .count_bcd  (count_bcd),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse)
`ifdef CDT_ALARM_EN
    ,
    .alarm      (alarm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Drive one cycle of commands, advance past the edge, then release them.
  task automatic cmd(input logic l, input logic s, input logic p, input logic t,
                     input logic [15:0] prog);
    load = l; start = s; pause = p; tick = t; prog_bcd = prog;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; prog_bcd = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_count", count_bcd, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pulse", done_pulse, 1'b0);
`ifdef CDT_ALARM_EN
    check("rst_alarm", alarm, 1'b0);
`endif
    reset = 1'b1;

    // basic decrement
    cmd(1, 0, 0, 0, 16'h1234);
    check("load_1234", count_bcd, 16'h1234);
    check("load_idle_running", running, 1'b0);
    cmd(0, 1, 0, 0, 16'h0);
    check("start_running", running, 1'b1);
    cmd(0, 0, 0, 1, 16'h0);
    check("tick_1233", count_bcd, 16'h1233);
    check("tick_running", running, 1'b1);
    cmd(1, 0, 0, 0, 16'h0001);
    check("load_in_run_ignored", count_bcd, 16'h1233);
    check("load_in_run_running", running, 1'b1);

    // pause holds, tick in PAUSED ignored, minute borrow
    cmd(0, 0, 1, 0, 16'h0);
    check("pause_running", running, 1'b0);
    cmd(0, 0, 0, 1, 16'h0);
    check("tick_paused", count_bcd, 16'h1233);
    cmd(1, 0, 0, 0, 16'h0100);
    cmd(0, 0, 0, 1, 16'h0);
    check("tick_idle", count_bcd, 16'h0100);
    cmd(0, 1, 0, 0, 16'h0);
    cmd(0, 0, 0, 1, 16'h0);
    check("borrow_0059", count_bcd, 16'h0059);

    // run to zero
    cmd(0, 0, 1, 0, 16'h0);
    cmd(1, 0, 0, 0, 16'h0002);
    cmd(0, 1, 0, 0, 16'h0);
    cmd(0, 0, 0, 1, 16'h0);
    check("cnt_0001", count_bcd, 16'h0001);
    check("cnt_0001_done", done, 1'b0);
    cmd(0, 0, 0, 1, 16'h0);
    check("zero_count", count_bcd, 16'h0000);
    check("zero_done", done, 1'b1);
    check("zero_pulse", done_pulse, 1'b1);
    check("zero_running", running, 1'b0);
`ifdef CDT_ALARM_EN
    check("alarm_entry", alarm, 1'b0);
`endif
    cmd(0, 0, 0, 0, 16'h0);
    check("pulse_one_cycle", done_pulse, 1'b0);
    check("done_held", done, 1'b1);
    cmd(0, 0, 0, 1, 16'h0);
    check("no_wrap_below_zero", count_bcd, 16'h0000);
    check("done_tick_pulse", done_pulse, 1'b0);
`ifdef CDT_ALARM_EN
    check("alarm_tog1", alarm, 1'b1);
`endif
    cmd(0, 0, 0, 1, 16'h0);
`ifdef CDT_ALARM_EN
    check("alarm_tog2", alarm, 1'b0);
`endif
    cmd(0, 1, 0, 0, 16'h0);
    check("start_in_done_done", done, 1'b1);
    check("start_in_done_running", running, 1'b0);

    // clamp and zero start
    cmd(1, 0, 0, 0, 16'h9999);
    check("clamp_5959", count_bcd, 16'h5959);
    check("load_clears_done", done, 1'b0);
    cmd(1, 0, 0, 0, 16'h7386);
    check("clamp_5356", count_bcd, 16'h5356);
    cmd(1, 0, 0, 0, 16'h0000);
    cmd(0, 1, 0, 0, 16'h0);
    check("zero_start_done", done, 1'b1);
    check("zero_start_pulse", done_pulse, 1'b1);
    cmd(0, 0, 0, 0, 16'h0);
    check("zero_start_pulse_off", done_pulse, 1'b0);

    // pause beats tick
    cmd(1, 0, 0, 0, 16'h0530);
    cmd(0, 1, 0, 0, 16'h0);
    cmd(0, 0, 1, 1, 16'h0);
    check("pause_tick_count", count_bcd, 16'h0530);
    check("pause_tick_running", running, 1'b0);
    cmd(0, 1, 0, 0, 16'h0);
    check("resume_running", running, 1'b1);
    cmd(0, 0, 0, 1, 16'h0);
    check("resume_0529", count_bcd, 16'h0529);

    // priorities
    cmd(0, 1, 1, 0, 16'h0);
    check("pause_over_start", running, 1'b0);
    cmd(1, 1, 0, 0, 16'h0412);
    check("load_over_start_run", running, 1'b0);
    check("load_over_start_cnt", count_bcd, 16'h0412);

    // reset mid-RUN
    cmd(0, 1, 0, 0, 16'h0);
    check("run_0412", running, 1'b1);
    reset = 1'b0;
    cmd(0, 0, 0, 1, 16'h0);
    reset = 1'b1;
    check("midrun_rst_count", count_bcd, 16'h0000);
    check("midrun_rst_running", running, 1'b0);
    cmd(0, 0, 0, 1, 16'h0);
    check("post_rst_idle_tick", count_bcd, 16'h0000);

    // reset from DONE with alarm high
    cmd(1, 0, 0, 0, 16'h0001);
    cmd(0, 1, 0, 0, 16'h0);
    cmd(0, 0, 0, 1, 16'h0);
    check("done_from_one", done, 1'b1);
    cmd(0, 0, 0, 1, 16'h0);
`ifdef CDT_ALARM_EN
    check("alarm_before_rst", alarm, 1'b1);
`endif
    reset = 1'b0;
    cmd(0, 0, 0, 0, 16'h0);
    reset = 1'b1;
    check("done_rst_done", done, 1'b0);
`ifdef CDT_ALARM_EN
    check("done_rst_alarm", alarm, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
